// File: rtl/logic_stream_unit_pkg.sv
// Shared definitions for logic_stream_unit: operation codes and op-select width.
package logic_stream_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_OR_ACC = 3'd7
  } op_e;

endpackage

// File: rtl/logic_stream_unit_op_comb.sv
// logic_op_comb: pure combinational WIDTH-bit bitwise function y = f(op, a, b).
// Ports: op (operation select), a/b (operands), y_c (result).
// OR_ACC passes a through; folding with the accumulator happens in the top.
module logic_op_comb
  import logic_stream_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c
);

  always_comb begin
    y_c = '0;
    case (op_e'(op))
      OP_AND:    y_c = a & b;
      OP_OR:     y_c = a | b;
      OP_XOR:    y_c = a ^ b;
      OP_NAND:   y_c = ~(a & b);
      OP_NOR:    y_c = ~(a | b);
      OP_XNOR:   y_c = ~(a ^ b);
      OP_NOT_A:  y_c = ~a;
      OP_OR_ACC: y_c = a;
      default:   y_c = '0;
    endcase
  end

endmodule

// File: rtl/logic_stream_unit.sv
// logic_stream_unit: registered WIDTH-bit bitwise logic unit on a valid/ready
// stream, with an OR-accumulate op that folds a multi-beat packet into one result.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_a/in_b/in_op/in_last
// input stream; out_valid/out_ready/out_/out_any/out_count output stream.
module logic_stream_unit
  import logic_stream_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OP_W-1:0]    in_op,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_,
  output logic               out_any,
  output logic [COUNT_W-1:0] out_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_any_q, out_any_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   op_y;
  logic [COUNT_W-1:0] cnt_inc;
  logic               accept;
  logic               is_acc;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op  (in_op),
    .a   (in_a),
    .b   (in_b),
    .y_c (op_y)
  );

  // Combinational ready: the output slot is free or is being drained this cycle.
  assign in_ready = ~reset && (~out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_acc   = (op_e'(in_op) == OP_OR_ACC);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_W'(1);

  // Next-state: drain, then load a result or fold into the accumulator.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_any_d   = out_any_q;
    out_count_d = out_count_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (is_acc) begin
        if (in_last) begin
          out_valid_d = 1'b1;
          out_d       = acc_q | in_a;
          out_count_d = cnt_inc;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_q | in_a;
          cnt_d = cnt_inc;
        end
      end else begin
        // Non-accumulate ops pass through an open packet without touching acc/cnt.
        out_valid_d = 1'b1;
        out_d       = op_y;
        out_count_d = COUNT_W'(1);
      end
      out_any_d = |out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_any_q   <= 1'b0;
      out_count_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_any_q   <= out_any_d;
      out_count_q <= out_count_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_      = out_q;
  assign out_any   = out_any_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_logic_stream_unit.sv
// Directed self-checking bench for logic_stream_unit. A second instance with
// COUNT_W=2 shares all inputs to exercise counter saturation.
module tb_logic_stream_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        in_last;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [15:0] out_, out2;
  logic        out_any, out_any2;
  logic [7:0]  out_count;
  logic [1:0]  out_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_stream_unit #(.WIDTH(16), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_(out_),
    .out_any(out_any), .out_count(out_count)
  );

  logic_stream_unit #(.WIDTH(16), .COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_(out2),
    .out_any(out_any2), .out_count(out_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic last);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_last = last;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    drive(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tick(); tick();
    checks++;
    if ({out_valid, out_, out_any, out_count} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b d=%h any=%b cnt=%0d exp all 0", out_valid, out_, out_any, out_count);
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_ops();
    logic [15:0] exp_tab [7];
    exp_tab = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'hFFF0, 16'hF000, 16'hF00F, 16'hFF00};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 3'(i), 16'h00FF, 16'h0F0F, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL ops_in_ready op=%0d got %b exp 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ !== exp_tab[i] || out_any !== 1'b1 || out_count !== 8'd1) begin
        errors++;
        $display("FAIL ops_result op=%0d got v=%b d=%h any=%b cnt=%0d exp v=1 d=%h any=1 cnt=1",
                 i, out_valid, out_, out_any, out_count, exp_tab[i]);
      end
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ops_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_or_acc();
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 16'h0001, 16'hFFFF, 1'b0); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_beat1_no_out got v=%b exp 0", out_valid); end
    drive(1'b1, 3'd7, 16'h0010, 16'hFFFF, 1'b0); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_beat2_no_out got v=%b exp 0", out_valid); end
    drive(1'b1, 3'd7, 16'h0100, 16'hFFFF, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h0111 || out_any !== 1'b1 || out_count !== 8'd3) begin
      errors++; $display("FAIL acc_packet got v=%b d=%h any=%b cnt=%0d exp v=1 d=0111 any=1 cnt=3", out_valid, out_, out_any, out_count);
    end
    drive(1'b1, 3'd7, 16'h8000, 16'h0000, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h8000 || out_count !== 8'd1) begin
      errors++; $display("FAIL acc_single got v=%b d=%h cnt=%0d exp v=1 d=8000 cnt=1", out_valid, out_, out_count);
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0); tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h1111, 16'h0101, 1'b0); tick();
    drive(1'b1, 3'd2, 16'h2222, 16'h0202, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ !== 16'h1010) begin
        errors++; $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=1010", c, in_ready, out_valid, out_);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h2020) begin
      errors++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=2020", out_valid, out_);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got v=%b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd7, 16'h0000, 16'hFFFF, (i == 5));
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    checks++;
    if (out_valid2 !== 1'b1 || out2 !== 16'h0 || out_any2 !== 1'b0 || out_count2 !== 2'd3) begin
      errors++; $display("FAIL sat_cw2 got v=%b d=%h any=%b cnt=%0d exp v=1 d=0000 any=0 cnt=3", out_valid2, out2, out_any2, out_count2);
    end
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h0 || out_any !== 1'b0 || out_count !== 8'd6) begin
      errors++; $display("FAIL sat_cw8 got v=%b d=%h any=%b cnt=%0d exp v=1 d=0000 any=0 cnt=6", out_valid, out_, out_any, out_count);
    end
    tick();
  endtask

  task automatic test_interleave();
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 16'h0002, 16'h0000, 1'b0); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL il_open got v=%b exp 0", out_valid); end
    drive(1'b1, 3'd0, 16'hFFFF, 16'h1234, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h1234 || out_count !== 8'd1) begin
      errors++; $display("FAIL il_and got v=%b d=%h cnt=%0d exp v=1 d=1234 cnt=1", out_valid, out_, out_count);
    end
    drive(1'b1, 3'd7, 16'h0004, 16'h0000, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h0006 || out_count !== 8'd2) begin
      errors++; $display("FAIL il_close got v=%b d=%h cnt=%0d exp v=1 d=0006 cnt=2", out_valid, out_, out_count);
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0); tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 16'h0040, 16'h0000, 1'b0); tick();
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 16'h00F0, 16'h0F00, 1'b0); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h0FF0) begin
      errors++; $display("FAIL rm_stalled got v=%b d=%h exp v=1 d=0ff0", out_valid, out_);
    end
    reset = 1'b1;
    drive(1'b1, 3'd7, 16'h0020, 16'h0000, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready got %b exp 0", in_ready); end
    tick();
    checks++;
    if ({out_valid, out_, out_any, out_count} !== 26'd0) begin
      errors++; $display("FAIL rm_cleared got v=%b d=%h any=%b cnt=%0d exp all 0", out_valid, out_, out_any, out_count);
    end
    reset = 1'b0; out_ready = 1'b1;
    drive(1'b1, 3'd7, 16'h0008, 16'h0000, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ !== 16'h0008 || out_any !== 1'b1 || out_count !== 8'd1) begin
      errors++; $display("FAIL rm_post got v=%b d=%h any=%b cnt=%0d exp v=1 d=0008 any=1 cnt=1", out_valid, out_, out_any, out_count);
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    test_reset();
    test_ops();
    test_or_acc();
    test_backpressure();
    test_saturation();
    test_interleave();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
